// File: rtl/prbs_checker_pkg.sv
// -----------------------------------------------------------------------------
// prbs_checker_pkg
// Shared definitions for the 8-bit PRBS generator and checker:
//   - LFSR_SEED  : power-up seed used by the generator (8'h8A)
//   - LFSR_TAPS  : tap mask for x^8+x^6+x^5+x^4+1 (bits 7,5,4,3)
//   - lfsr_next(): one-step next-word predictor
//   - state_t    : checker state encoding
// -----------------------------------------------------------------------------
package prbs_checker_pkg;

  localparam logic [7:0] LFSR_SEED = 8'h8A;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,  // no reference word held yet
    ST_SEARCH = 2'd1,  // following the stream, counting consecutive matches
    ST_LOCKED = 2'd2   // flywheeling on the local prediction, counting errors
  } state_t;

  // Shift left, feeding the XOR of the tapped bits into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] d);
    return {d[6:0], ^(d & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Self-synchronising checker for an 8-bit PRBS stream. It loads a reference
// word, requires LOCK_COUNT consecutive correct predictions to lock, and then
// runs on its own prediction (flywheel) so each corrupted word costs exactly
// one error. UNLOCK_COUNT consecutive errors drop it back to searching.
//
// Parameters
//   LOCK_COUNT   : consecutive matches (after the first loaded word) to lock
//   UNLOCK_COUNT : consecutive mismatches while locked to unlock
//   CNT_W        : width of the saturating error counter
// Ports
//   clk          : clock, rising edge
//   reset        : synchronous active-high reset
//   data_in      : received 8-bit word
//   data_valid   : data_in is sampled only when high
//   err_clear    : synchronous clear of error_count
//   locked       : registered, high while in LOCKED
//   err_pulse    : registered one-cycle pulse per mismatched word in LOCKED
//   error_count  : saturating count of mismatched words in LOCKED
// -----------------------------------------------------------------------------
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int LOCK_COUNT   = 4,
  parameter int UNLOCK_COUNT = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             err_clear,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] error_count
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_COUNT + 1);

  // Count value that, when one more event arrives, completes the threshold.
  localparam logic [MW-1:0] LOCK_LAST   = MW'(LOCK_COUNT - 1);
  localparam logic [UW-1:0] UNLOCK_LAST = UW'(UNLOCK_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_reg;
  logic [7:0]       prev_reg;
  logic [MW-1:0]    match_cnt_reg;
  logic [UW-1:0]    mism_cnt_reg;
  logic             locked_reg;
  logic             err_pulse_reg;
  logic [CNT_W-1:0] error_count_reg;

  logic [7:0] predicted;
  logic       hit;
  logic       is_zero;
  logic       locked_miss;

  assign predicted   = lfsr_next(prev_reg);
  assign hit         = (data_in == predicted);
  assign is_zero     = (data_in == 8'h00);
  assign locked_miss = data_valid && (state_reg == ST_LOCKED) && !hit;

  // State machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      prev_reg      <= 8'h00;
      match_cnt_reg <= '0;
      mism_cnt_reg  <= '0;
      locked_reg    <= 1'b0;
      err_pulse_reg <= 1'b0;
    end else begin
      err_pulse_reg <= 1'b0;
      if (data_valid) begin
        case (state_reg)
          ST_IDLE: begin
            // An all-zero word is the LFSR lock-up state and never a valid seed.
            if (!is_zero) begin
              prev_reg      <= data_in;
              match_cnt_reg <= '0;
              state_reg     <= ST_SEARCH;
            end
          end

          ST_SEARCH: begin
            // Follow the received stream so a mismatch re-seeds the predictor.
            prev_reg <= data_in;
            if (hit) begin
              match_cnt_reg <= match_cnt_reg + 1'b1;
              if (match_cnt_reg == LOCK_LAST) begin
                state_reg    <= ST_LOCKED;
                locked_reg   <= 1'b1;
                mism_cnt_reg <= '0;
              end
            end else begin
              match_cnt_reg <= '0;
              if (is_zero) begin
                state_reg <= ST_IDLE;
              end
            end
          end

          ST_LOCKED: begin
            if (hit) begin
              prev_reg     <= predicted;
              mism_cnt_reg <= '0;
            end else begin
              err_pulse_reg <= 1'b1;
              if (mism_cnt_reg == UNLOCK_LAST) begin
                // Too many consecutive errors: resynchronise on this word.
                prev_reg      <= data_in;
                match_cnt_reg <= '0;
                mism_cnt_reg  <= '0;
                locked_reg    <= 1'b0;
                state_reg     <= is_zero ? ST_IDLE : ST_SEARCH;
              end else begin
                // Flywheel: ignore the bad word and keep our own sequence.
                prev_reg     <= predicted;
                mism_cnt_reg <= mism_cnt_reg + 1'b1;
              end
            end
          end

          default: begin
            state_reg     <= ST_IDLE;
            match_cnt_reg <= '0;
            mism_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating error counter. A clear that coincides with a new error keeps
  // that error, so no event is ever lost to the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_count_reg <= '0;
    end else if (err_clear) begin
      error_count_reg <= locked_miss ? CNT_ONE : '0;
    end else if (locked_miss && (error_count_reg != '1)) begin
      error_count_reg <= error_count_reg + CNT_ONE;
    end
  end

  assign locked      = locked_reg;
  assign err_pulse   = err_pulse_reg;
  assign error_count = error_count_reg;

endmodule

// File: tb/tb_prbs_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_checker
// Directed bench for prbs_checker. Two instances share the stimulus: the
// default one (CNT_W=16) and a narrow one (CNT_W=4) for saturation.
// Reference sequence from seed 8A:
//   8A 14 29 52 A5 4A 95 2A 54 A9 53 A7 4E 9D 3B ...
// -----------------------------------------------------------------------------
module tb_prbs_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        err_clear;

  logic        locked,  err_pulse;
  logic [15:0] error_count;
  logic        locked4, err_pulse4;
  logic [3:0]  error_count4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  prbs_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .err_clear(err_clear), .locked(locked), .err_pulse(err_pulse),
    .error_count(error_count)
  );

  prbs_checker #(.LOCK_COUNT(4), .UNLOCK_COUNT(4), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .err_clear(err_clear), .locked(locked4), .err_pulse(err_pulse4),
    .error_count(error_count4)
  );

  // Independent reference for the generator: taps at bits 7,5,4,3.
  function automatic logic [7:0] ref_next(input logic [7:0] d);
    return {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]};
  endfunction

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cyc(input logic [7:0] d, input logic v, input logic c,
                     input logic r);
    @(negedge clk);
    data_in    = d;
    data_valid = v;
    err_clear  = c;
    reset      = r;
    @(posedge clk);
    #1;
    $display("cyc rst=%0b v=%0b clr=%0b d=%02h -> locked=%0b err_pulse=%0b error_count=%0d",
             r, v, c, d, locked, err_pulse, error_count);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_word;

  initial begin
    data_in = 8'h00; data_valid = 1'b0; err_clear = 1'b0; reset = 1'b1;

    // Reset with valid data present: everything stays cleared.
    cyc(8'h8A, 1'b1, 1'b0, 1'b1);
    cyc(8'h14, 1'b1, 1'b1, 1'b1);
    chk("reset_locked",  locked,      0);
    chk("reset_pulse",   err_pulse,   0);
    chk("reset_count",   error_count, 0);

    // Lock on 8A,14,29,52,A5 with a stall between 29 and 52.
    cyc(8'h8A, 1'b1, 1'b0, 1'b0);
    cyc(8'h14, 1'b1, 1'b0, 1'b0);
    cyc(8'h29, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b0, 1'b0, 1'b0);          // ignored: data_valid low
    chk("stall_no_lock", locked, 0);
    cyc(8'h52, 1'b1, 1'b0, 1'b0);
    chk("pre_lock",      locked, 0);
    cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("lock_a5",       locked,      1);
    chk("lock_count0",   error_count, 0);

    // Single corrupted word 4A->4B, then the true next word 95.
    cyc(8'h4B, 1'b1, 1'b0, 1'b0);
    chk("single_pulse",  err_pulse,   1);
    chk("single_count",  error_count, 1);
    cyc(8'h95, 1'b1, 1'b0, 1'b0);
    chk("single_pulse_off", err_pulse, 0);
    chk("single_still_locked", locked, 1);
    chk("single_count_hold", error_count, 1);
    cyc(8'h00, 1'b0, 1'b0, 1'b0);
    chk("idle_no_pulse", err_pulse, 0);

    // Clear, then four consecutive FF words unlock the checker.
    cyc(8'h00, 1'b0, 1'b1, 1'b0);
    chk("clear_count",   error_count, 0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("three_bad_locked", locked, 1);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("unlock_locked", locked,      0);
    chk("unlock_count",  error_count, 4);
    chk("unlock_pulse",  err_pulse,   1);

    // Leading zero words are ignored in IDLE; lock after A5.
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 1'b1, 1'b0, 1'b0);
    cyc(8'h8A, 1'b1, 1'b0, 1'b0);
    cyc(8'h14, 1'b1, 1'b0, 1'b0);
    cyc(8'h29, 1'b1, 1'b0, 1'b0);
    cyc(8'h52, 1'b1, 1'b0, 1'b0);
    chk("zero_pre_lock", locked, 0);
    cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("zero_lock",     locked, 1);

    // Reach error_count=5 without four consecutive errors.
    // Slots: 4A 95 2A 54 A9 53 A7 | 4E
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'h2A, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'h53, 1'b1, 1'b0, 1'b0);
    cyc(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("count_five",    error_count, 5);
    cyc(8'hFF, 1'b1, 1'b1, 1'b0);          // mismatch with clear
    chk("clear_plus_err", error_count, 1);
    chk("clear_locked",   locked,      1);

    // Saturation: 20 errors in groups of three wrong + one right.
    cyc(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(8'h8A, 1'b1, 1'b0, 1'b0);
    cyc(8'h14, 1'b1, 1'b0, 1'b0);
    cyc(8'h29, 1'b1, 1'b0, 1'b0);
    cyc(8'h52, 1'b1, 1'b0, 1'b0);
    cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("sat_lock", locked4, 1);
    exp_word = 8'h4A;
    for (int i = 0; i < 26; i++) begin
      cyc(((i % 4) == 3) ? exp_word : 8'hFF, 1'b1, 1'b0, 1'b0);
      exp_word = ref_next(exp_word);
    end
    chk("sat_wide_count",  error_count,  20);
    chk("sat_narrow_count", error_count4, 15);
    chk("sat_still_locked", locked, 1);

    // Reset while locked with data_valid held high (and a bad word present).
    cyc(8'hFF, 1'b1, 1'b0, 1'b1);
    chk("mid_reset_locked", locked,      0);
    chk("mid_reset_pulse",  err_pulse,   0);
    chk("mid_reset_count",  error_count, 0);
    chk("mid_reset_count4", error_count4, 0);
    cyc(8'h8A, 1'b1, 1'b0, 1'b0);
    cyc(8'h14, 1'b1, 1'b0, 1'b0);
    cyc(8'h29, 1'b1, 1'b0, 1'b0);
    cyc(8'h52, 1'b1, 1'b0, 1'b0);
    chk("relock_pending", locked, 0);
    cyc(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("relock",         locked, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
